// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory responder and its write buffer.
package mem_pkg;

  localparam int unsigned WORD_W           = 16;
  localparam int unsigned DEFAULT_ADDR_W   = 10;
  localparam int unsigned DEFAULT_WB_DEPTH = 2;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] idx;
    logic [WORD_W-1:0]         data;
  } wb_entry_t;

endpackage

// File: rtl/write_buffer_fifo.sv
// Posted-store FIFO. It also presents every slot in age order, oldest first,
// so the owner can search it for store-to-load forwarding.
module write_buffer_fifo
  import mem_pkg::*;
#(
  parameter int unsigned Depth = DEFAULT_WB_DEPTH,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  wb_entry_t       entry_i,
  output wb_entry_t       head_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o,
  output wb_entry_t       entries_o [Depth],
  output logic [Depth-1:0] valid_o
);

  wb_entry_t       mem_q [Depth];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;
  logic [PtrW:0]   pos;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[tail_q] <= entry_i;
        tail_q        <= ptr_inc(tail_q);
      end
      if (do_pop) begin
        head_q <= ptr_inc(head_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Slot k of the view is the k-th oldest entry; only the first count_q are live.
  always_comb begin
    pos = '0;
    for (int k = 0; k < Depth; k++) begin
      pos = {1'b0, head_q} + (PtrW + 1)'(k);
      if (pos >= (PtrW + 1)'(Depth)) pos = pos - (PtrW + 1)'(Depth);
      entries_o[k] = mem_q[pos[PtrW-1:0]];
      valid_o[k]   = (32'(k) < 32'(count_q));
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory end of the memory stage: zero-latency loads with forwarding from a
// posted write buffer that drains into a single-port array on idle cycles.
module data_mem_responder
  import mem_pkg::*;
#(
  // Must equal DEFAULT_ADDR_W: wb_entry_t sizes its index field from the package.
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned WB_DEPTH = DEFAULT_WB_DEPTH,
  localparam int unsigned CNT_W   = $clog2(WB_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       req_addr,
  input  logic [15:0]       req_wdata,
  input  logic              req_we,
  input  logic              req_re,
  output logic [15:0]       rd_data,
  output logic              mem_stall,
  output logic [CNT_W-1:0]  wb_count
);

  logic [ADDR_W-1:0] idx;
  logic              full, empty, load, push, drain;
  wb_entry_t         push_entry, head_entry;
  wb_entry_t         entries [WB_DEPTH];
  logic [WB_DEPTH-1:0] valid;
  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  assign idx = req_addr[ADDR_W-1:0];

  always_comb begin
    load       = req_re & ~req_we;
    mem_stall  = req_we & full;
    push       = req_we & ~full;
    // Loads own the array port, so only idle or stalled cycles drain.
    drain      = ~empty & ((~req_we & ~req_re) | mem_stall);
    push_entry = '{idx: idx, data: req_wdata};
  end

  // Entries are oldest-first, so the last match is the youngest store.
  always_comb begin
    rd_data = '0;
    if (load) begin
      rd_data = mem_q[idx];
      for (int k = 0; k < WB_DEPTH; k++) begin
        if (valid[k] && entries[k].idx == idx) rd_data = entries[k].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (drain && !rst) begin
      mem_q[head_entry.idx] <= head_entry.data;
    end
  end

  write_buffer_fifo #(
    .Depth(WB_DEPTH)
  ) u_write_buffer (
    .clk_i    (clk),
    .rst_i    (rst),
    .push_i   (push),
    .pop_i    (drain),
    .entry_i  (push_entry),
    .head_o   (head_entry),
    .count_o  (wb_count),
    .full_o   (full),
    .empty_o  (empty),
    .entries_o(entries),
    .valid_o  (valid)
  );

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory end of the pipeline's memory-stage interface. It answers loads and stores issued by the datapath: it takes the address, store data, write enable and load select, and returns read data in the same cycle.
- Stores are posted into a small FIFO write buffer. Loads check that buffer first (store-to-load forwarding).
- Buffered writes drain into a single-port word array on free cycles.
- When the buffer is full, the block raises a stall to the hazard unit.

Parameters:
- ADDR_W, 10, word-address bits used to index the array (depth 2^ADDR_W words).
- WB_DEPTH, 2, write-buffer entries (≥1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_addr  in  16  word address from memory stage (ALU result); only bits [ADDR_W-1:0] are used.
- req_wdata  in  16  store data from memory stage.
- req_we  in  1  store request.
- req_re  in  1  load request; ignored when req_we=1.
- rd_data  out  16  load data, combinational.
- mem_stall  out  1  hold the pipeline this cycle (combinational, to hazard unit).
- wb_count  out  $clog2(WB_DEPTH+1)  current write-buffer occupancy.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- On reset:
  - buffer emptied; head, tail and count cleared.
  - wb_count=0, mem_stall=0.
  - pending buffered stores are discarded, never written to the array.
  - array contents are not reset.
- Index: idx = req_addr[ADDR_W-1:0]. Higher address bits alias.
- Read, combinational, zero latency:
  - if req_re=1 and req_we=0: rd_data = data of the youngest valid buffer entry whose index equals idx; otherwise array[idx].
  - in every other case rd_data = 16'h0000.
- Stall:
  - mem_stall = req_we & (wb_count==WB_DEPTH).
  - loads never stall.
- Push: when req_we=1 and mem_stall=0, {idx, req_wdata} is pushed at the tail on the clock edge.
- Drain, one entry per cycle:
  - condition: buffer non-empty and (req_we=0 and req_re=0, or mem_stall=1).
  - action: the head entry is written into the array and popped on the edge.
  - a load cycle blocks draining (single array port).
- Push and drain in the same cycle cannot occur:
  - a push requires mem_stall=0 and req_we=1, which blocks drain.
  - a stall cycle drains only, so the retried store is accepted on the next cycle.
- Count update: wb_count +1 on push, -1 on drain, held otherwise.
- Ordering: drains leave in FIFO order, so repeated stores to the same index land in program order.
- Forwarding is required because a load may read an index whose newest value is still buffered.
- Both pointers wrap modulo WB_DEPTH. Full is when count==WB_DEPTH; empty is when count==0.
- Illegal input: req_we=1 with req_re=1 is handled as a store only.

Decomposition:
- Package mem_pkg:
  - WORD_W=16.
  - default ADDR_W and WB_DEPTH.
  - typedef wb_entry_t {logic [ADDR_W-1:0] idx; logic [WORD_W-1:0] data;}.
- Sub-module write_buffer_fifo:
  - ports: push, pop, entry in, head entry out, count, full, empty.
  - exposes all entries plus valid bits for the forwarding search.
- Top level holds the array, the read/forwarding mux, and the stall/drain decisions.

Test Plan:
- Reset, then a store of 0x1234 to 0x0005, then a load of 0x0005 on the next cycle → rd_data=0x1234 from the buffer, wb_count=1, mem_stall=0.
- Store 0xAAAA then 0xBBBB to 0x0007 back-to-back, then load 0x0007 → rd_data=0xBBBB (youngest match). After two idle cycles wb_count=0 and a load of 0x0007 returns 0xBBBB from the array.
- WB_DEPTH=2, stores to 0x0001, 0x0002, 0x0003 on consecutive cycles:
  - third cycle: mem_stall=1, 0x0001 drained, wb_count 2→1.
  - next cycle: store to 0x0003 accepted, wb_count=2, mem_stall=0.
- Buffer holds 2 entries with loads to unrelated addresses every cycle → wb_count stays 2. Idle cycles then drain one entry per cycle.
- Array[0x0009]=0x0055, buffered store of 0x7777 to 0x0009, rst asserted one cycle → wb_count=0, mem_stall=0, and a load of 0x0009 returns 0x0055.
- ADDR_W=10: store 0xCAFE to 0x0403, drain it, load 0x0003 → 0xCAFE (aliasing). rd_data=0x0000 whenever req_re=0.
